// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the I2C bus arbiter
//
// Holds the arbiter state encoding, the default bus-free guard and grant
// timeout lengths, the requester index assignments, and an index-width helper.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } arb_state_e;

    // tBUF at 50 MHz with margin
    localparam logic [15:0] DEF_GUARD_CYCLES   = 16'd300;
    localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd5000000;

    localparam int REQ_ADV7513_INIT = 0;
    localparam int REQ_ADV7513_READ = 1;
    localparam int REQ_CAMERA_CFG   = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// rtl/i2c_bus_arbiter_rr_pick.sv - combinational round-robin picker
//
// Ports:
//   elig       in  NUM_REQ  eligible requests (req & ~lockout)
//   last_idx   in  IDX_W    index of the previous owner
//   winner     out NUM_REQ  one-hot winner
//   winner_idx out IDX_W    binary index of the winner
//   valid      out 1        a winner exists
module rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    int               k;
    logic [IDX_W-1:0] kk;

    // Search starts one past the previous owner and wraps, so the previous
    // owner is considered last.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        k          = 0;
        kk         = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k  = (int'(last_idx) + i) % NUM_REQ;
            kk = IDX_W'(k);
            if (!valid && elig[kk]) begin
                valid      = 1'b1;
                winner[kk] = 1'b1;
                winner_idx = kk;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin owner arbiter for a shared I2C bus
//
// Ports:
//   clk          in  1        single clock
//   reset        in  1        synchronous, active-high
//   req          in  NUM_REQ  level request per requester
//   grant        out NUM_REQ  registered one-hot grant
//   scl_oe_in    in  NUM_REQ  per-requester SCL pull-low enable
//   sda_oe_in    in  NUM_REQ  per-requester SDA pull-low enable
//   scl_oe       out 1        owner's SCL pull-low enable, 0 when no grant
//   sda_oe       out 1        owner's SDA pull-low enable, 0 when no grant
//   busy         out 1        high in GRANT or GUARD
//   timeout_err  out NUM_REQ  sticky per-requester timeout flags
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int          NUM_REQ        = 3,
    parameter logic [15:0] GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    input  logic [NUM_REQ-1:0] scl_oe_in,
    input  logic [NUM_REQ-1:0] sda_oe_in,
    output logic               scl_oe,
    output logic               sda_oe,
    output logic               busy,
    output logic [NUM_REQ-1:0] timeout_err
);

    localparam int               IDX_W    = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [15:0]        guard_cnt_q, guard_cnt_d;
    logic [31:0]        hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] lockout_q, lockout_d;
    logic [NUM_REQ-1:0] terr_q, terr_d;

    logic [NUM_REQ-1:0] pick_winner;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               owner_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .elig       (req & ~lockout_q),
        .last_idx   (owner_q),
        .winner     (pick_winner),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // grant_q is one-hot or zero, so masking with it selects the owner's bit
    assign owner_req = |(grant_q & req);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        guard_cnt_d = guard_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        terr_d      = terr_q;
        // A lockout bit clears once its req has been sampled low
        lockout_d   = lockout_q & req;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_GRANT;
                    grant_d    = pick_winner;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    state_d     = ST_GUARD;
                    grant_d     = '0;
                    guard_cnt_d = GUARD_CYCLES - 16'd1;
                end else if (hold_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                    // Forced revoke: owner stays locked out until it drops req
                    state_d     = ST_GUARD;
                    grant_d     = '0;
                    guard_cnt_d = GUARD_CYCLES - 16'd1;
                    terr_d      = terr_q | grant_q;
                    lockout_d   = lockout_d | grant_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= LAST_RST;
            guard_cnt_q <= '0;
            hold_cnt_q  <= '0;
            lockout_q   <= '0;
            terr_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            guard_cnt_q <= guard_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            lockout_q   <= lockout_d;
            terr_q      <= terr_d;
        end
    end

    assign grant       = grant_q;
    assign scl_oe      = |(grant_q & scl_oe_in);
    assign sda_oe      = |(grant_q & sda_oe_in);
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - scoreboard bench for i2c_bus_arbiter
module tb_i2c_bus_arbiter;

    localparam int G = 4;
    localparam int T = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = '0;
    logic [2:0] scl_oe_in = '0;
    logic [2:0] sda_oe_in = '0;
    logic [2:0] grant;
    logic       scl_oe;
    logic       sda_oe;
    logic       busy;
    logic [2:0] timeout_err;

    i2c_bus_arbiter #(
        .NUM_REQ        (3),
        .GUARD_CYCLES   (16'd4),
        .TIMEOUT_CYCLES (32'd100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .scl_oe_in   (scl_oe_in),
        .sda_oe_in   (sda_oe_in),
        .scl_oe      (scl_oe),
        .sda_oe      (sda_oe),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [2:0] g;
        logic [2:0] te;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic [2:0] g, input logic [2:0] te);
        ev_t e;
        e.at = at;
        e.g  = g;
        e.te = te;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    // Monitor: every change of grant is an output event matched against the queue
    initial begin
        logic [2:0] prev;
        ev_t        e;
        wait (mon_en);
        prev = grant;
        forever begin
            @(negedge clk);
            #1;
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (grant !== prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant_change", 32'(grant), 32'(prev));
                end else begin
                    e = exp_q.pop_front();
                    chk("event_cycle", 32'(cyc), 32'(e.at));
                    chk("event_grant", 32'(grant), 32'(e.g));
                    chk("event_timeout_err", 32'(timeout_err), 32'(e.te));
                end
                prev = grant;
            end
        end
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: time limit reached with %0d events pending", exp_q.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        int c, g, n, h, r, o;

        // Reset state
        reset = 1'b1;
        tick(3);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick(1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_scl_oe", 32'(scl_oe), 32'd0);

        // Single requester: req at cycle 10, grant at cycle 11
        wait_until(10);
        req       = 3'b001;
        scl_oe_in = 3'b001;
        c = cyc;
        push(c + 1, 3'b001, 3'b000);
        tick(1);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_scl_oe", 32'(scl_oe), 32'd1);
        chk("single_sda_oe", 32'(sda_oe), 32'd0);
        scl_oe_in = 3'b110;
        sda_oe_in = 3'b001;
        #1;
        chk("single_scl_nonowner", 32'(scl_oe), 32'd0);
        chk("single_sda_owner", 32'(sda_oe), 32'd1);
        tick(5);
        c = cyc;
        req = 3'b000;
        push(c + 1, 3'b000, 3'b000);
        wait_until(c + G);
        chk("guard_busy", 32'(busy), 32'd1);
        wait_until(c + G + 1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Round robin 0,1,2,0 after reset, each owner releasing after 20 cycles
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        scl_oe_in = 3'b111;
        sda_oe_in = 3'b111;
        c = cyc;
        req = 3'b111;
        g = c + 1;
        push(g, 3'b001, 3'b000);
        for (int k = 0; k < 4; k++) begin
            o = k % 3;
            wait_until(g);
            chk("rot_scl_on", 32'(scl_oe), 32'd1);
            wait_until(g + 19);
            if (k == 3) req = 3'b000;
            else        req = req & ~(3'b001 << o);
            push(g + 20, 3'b000, 3'b000);
            wait_until(g + 20);
            if (k < 3) req = 3'b111;
            wait_until(g + 22);
            chk("rot_guard_scl", 32'(scl_oe), 32'd0);
            chk("rot_guard_sda", 32'(sda_oe), 32'd0);
            if (k < 3) begin
                g = g + 20 + G + 1;
                push(g, 3'b001 << ((k + 1) % 3), 3'b000);
            end
        end
        wait_until(g + 27);

        // Owner 1 releases while req[2] rises on the same cycle
        c = cyc;
        req = 3'b010;
        push(c + 1, 3'b010, 3'b000);
        wait_until(c + 8);
        n = cyc;
        req = 3'b100;
        push(n + 1, 3'b000, 3'b000);
        push(n + 6, 3'b100, 3'b000);
        for (int i = 1; i <= 5; i++) begin
            wait_until(n + i);
            chk("handoff_scl_off", 32'(scl_oe), 32'd0);
            chk("handoff_sda_off", 32'(sda_oe), 32'd0);
        end
        wait_until(n + 6);
        chk("handoff_scl_on", 32'(scl_oe), 32'd1);
        wait_until(n + 10);
        c = cyc;
        req = 3'b000;
        push(c + 1, 3'b000, 3'b000);
        wait_until(c + 7);

        // Timeout on requester 0, lockout until req seen low
        c = cyc;
        req = 3'b001;
        g = c + 1;
        push(g, 3'b001, 3'b000);
        push(g + T, 3'b000, 3'b001);
        wait_until(g + 10);
        req = 3'b101;
        wait_until(g + 30);
        req = 3'b001;
        wait_until(g + T - 1);
        chk("timeout_still_granted", 32'(grant), 32'd1);
        wait_until(g + T + 1);
        req = 3'b011;
        wait_until(g + T + 3);
        req = 3'b001;
        wait_until(g + T + 30);
        chk("lockout_busy", 32'(busy), 32'd0);
        chk("lockout_timeout_err", 32'(timeout_err), 32'd1);
        h = cyc;
        req = 3'b000;
        wait_until(h + 1);
        req = 3'b001;
        push(h + 2, 3'b001, 3'b001);

        // Reset mid-grant
        wait_until(h + 5);
        req = 3'b111;
        wait_until(h + 10);
        r = cyc;
        reset = 1'b1;
        push(r + 1, 3'b000, 3'b000);
        wait_until(r + 1);
        chk("midrst_scl_oe", 32'(scl_oe), 32'd0);
        chk("midrst_sda_oe", 32'(sda_oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        req = 3'b110;
        push(r + 2, 3'b010, 3'b000);
        wait_until(r + 2);
        chk("postrst_scl_on", 32'(scl_oe), 32'd1);
        req = 3'b000;
        push(r + 3, 3'b000, 3'b000);
        wait_until(r + 10);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of I2C requesters (0 = adv7513 init, 1 = adv7513 reg read, 2 = camera config).
REQ-002 Parameter GUARD_CYCLES, default 16'd300: bus-free cycles enforced between owners (I2C tBUF at 50 MHz with margin).
REQ-003 Parameter TIMEOUT_CYCLES, default 32'd5000000: maximum grant hold in clk cycles before forced revoke.
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port reset, input, 1: synchronous reset, active-high.
REQ-006 Port req, input, NUM_REQ: level request per requester.
REQ-007 Port grant, output, NUM_REQ: one-hot grant, registered.
REQ-008 Port scl_oe_in, input, NUM_REQ: per-requester SCL pull-low enable.
REQ-009 Port sda_oe_in, input, NUM_REQ: per-requester SDA pull-low enable.
REQ-010 Port scl_oe, output, 1: muxed SCL pull-low enable to the open-drain pad.
REQ-011 Port sda_oe, output, 1: muxed SDA pull-low enable to the open-drain pad.
REQ-012 Port busy, output, 1: high in GRANT or GUARD state.
REQ-013 Port timeout_err, output, NUM_REQ: sticky per-requester timeout flags.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, GUARD; one owner index register of width clog2(NUM_REQ).
REQ-015 IDLE: any eligible req high -> GRANT next cycle, selected grant bit high that same edge; no eligible req -> stay IDLE.
REQ-016 Selection SHALL be round-robin: search starts at (last_owner+1) mod NUM_REQ and wraps; after reset last_owner = NUM_REQ-1, so requester 0 wins first.
REQ-017 GRANT: owner req low -> grant low next cycle, enter GUARD, load guard counter with GUARD_CYCLES-1.
REQ-018 GUARD: counter decrements each cycle; at 0 -> IDLE; a grant SHALL never be issued in GUARD.
REQ-019 Earliest re-grant after release: exactly GUARD_CYCLES+1 cycles after the grant-low edge.
REQ-020 GRANT: hold counter increments each cycle; reaching TIMEOUT_CYCLES-1 with req still high -> grant low next cycle, set timeout_err[owner], enter GUARD.
REQ-021 A revoked requester SHALL be ineligible until its req has been sampled low at least once (lockout bit per requester).
REQ-022 A req dropped before grant SHALL not be granted; no request queuing.
REQ-023 Non-owner req changes during GRANT SHALL have no effect on the current owner.
REQ-024 scl_oe/sda_oe SHALL equal scl_oe_in/sda_oe_in of the owner while grant is high (combinational from the registered grant); 0 otherwise, including GUARD and IDLE.
REQ-025 Owner release and another requester's rising req on the same cycle: release wins, newcomer waits for GUARD to expire.
REQ-026 grant SHALL be one-hot or zero at all times; timeout_err bits clear only on reset.

Reset
REQ-027 While reset is high at a clk edge: state = IDLE, grant = 0, last_owner = NUM_REQ-1, counters = 0, lockout = 0, timeout_err = 0.
REQ-028 During reset and the first cycle after it: scl_oe = 0, sda_oe = 0, busy = 0.
REQ-029 Reset asserted mid-GRANT or mid-GUARD SHALL abort immediately with no residual bus drive.

Structure
REQ-030 Shared package i2c_arb_pkg SHALL hold the state encoding, default GUARD_CYCLES and TIMEOUT_CYCLES, and the requester index constants.
REQ-031 One sub-module rr_pick: combinational round-robin picker (req & ~lockout, last_owner -> one-hot winner, valid).

Verification
REQ-032 req=3'b001 at cycle 10 -> grant=3'b001 at cycle 11; scl_oe follows scl_oe_in[0].
REQ-033 req=3'b111 simultaneous after reset with each owner releasing after 20 cycles -> grants in order 0,1,2,0, each separated by GUARD_CYCLES+1 idle cycles.
REQ-034 GUARD_CYCLES=4, owner 1 drops req at cycle N, req[2] rises at cycle N -> grant[2] at N+6, never earlier; scl_oe=sda_oe=0 during N+1..N+5.
REQ-035 TIMEOUT_CYCLES=100, req[0] held high -> grant[0] drops on cycle 101 after grant, timeout_err=3'b001; req[0] still high gets no re-grant until it goes low and high again.
REQ-036 reset pulsed mid-GRANT -> next cycle grant=0, scl_oe=0, timeout_err=0, and the first post-reset grant goes to the lowest active index.
